// File: rtl/alu_exec_unit.sv
// Execute-stage ALU with a valid/ready handshake on both sides.
// Logic ops, add/sub and slt complete in one registered cycle; sll/srl
// shift one bit per cycle through a working register so no barrel
// shifter is needed.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | no result held, ready for a new operation
// SHIFT | iterative shift in progress, input side stalled
// DONE  | result held on the outputs until downstream takes it
module alu_exec_unit #(
  parameter int WIDTH   = 32,
  parameter int TAG_W   = 5,
  parameter int SHAMT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       ALUControl,
  input  logic [WIDTH-1:0] SrcA,
  input  logic [WIDTH-1:0] SrcB,
  input  logic [TAG_W-1:0] tag_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] ALUResult,
  output logic             Zero,
  output logic [TAG_W-1:0] tag_out
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_SLT = 3'b101;

  localparam logic [SHAMT_W-1:0] SHAMT_ONE = SHAMT_W'(1);

  state_t             state_q, state_d;
  logic               out_valid_q, out_valid_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               zero_q, zero_d;
  logic [TAG_W-1:0]   tag_out_q, tag_out_d;
  logic [TAG_W-1:0]   tag_pend_q, tag_pend_d;
  logic [WIDTH-1:0]   work_q, work_d;
  logic [SHAMT_W-1:0] cnt_q, cnt_d;
  logic               shl_q, shl_d;

  logic               accept;
  logic               is_shift_in;
  logic               shift_left_in;
  logic [SHAMT_W-1:0] shamt_in;
  logic [WIDTH-1:0]   first_shift;
  logic [WIDTH-1:0]   work_step;
  logic [WIDTH-1:0]   quick_result;

  assign in_ready      = (state_q == IDLE) | ((state_q == DONE) & out_ready);
  assign accept        = in_valid & in_ready;
  assign is_shift_in   = (ALUControl[2:1] == 2'b11);
  assign shift_left_in = ~ALUControl[0];
  assign shamt_in      = SrcB[SHAMT_W-1:0];
  assign first_shift   = shift_left_in ? (SrcA << 1) : (SrcA >> 1);
  assign work_step     = shl_q ? (work_q << 1) : (work_q >> 1);

  assign out_valid = out_valid_q;
  assign ALUResult = result_q;
  assign Zero      = zero_q;
  assign tag_out   = tag_out_q;

  // Single-cycle result; shifts by 0 or 1 bit also finish here.
  always_comb begin
    quick_result = '0;
    case (ALUControl)
      OP_ADD:  quick_result = SrcA + SrcB;
      OP_SUB:  quick_result = SrcA - SrcB;
      OP_AND:  quick_result = SrcA & SrcB;
      OP_OR:   quick_result = SrcA | SrcB;
      OP_XOR:  quick_result = SrcA ^ SrcB;
      OP_SLT:  quick_result = {{(WIDTH-1){1'b0}}, ($signed(SrcA) < $signed(SrcB))};
      default: quick_result = (shamt_in == '0) ? SrcA : first_shift;
    endcase
  end

  // Next-state and datapath update. The first shift bit is taken in the
  // accept edge, so an N-bit shift presents its result N cycles after accept.
  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q;
    result_d    = result_q;
    zero_d      = zero_q;
    tag_out_d   = tag_out_q;
    tag_pend_d  = tag_pend_q;
    work_d      = work_q;
    cnt_d       = cnt_q;
    shl_d       = shl_q;

    case (state_q)
      IDLE, DONE: begin
        if (accept) begin
          if (is_shift_in && (shamt_in > SHAMT_ONE)) begin
            work_d      = first_shift;
            cnt_d       = shamt_in - SHAMT_ONE;
            shl_d       = shift_left_in;
            tag_pend_d  = tag_in;
            out_valid_d = 1'b0;
            state_d     = SHIFT;
          end else begin
            result_d    = quick_result;
            zero_d      = (quick_result == '0);
            tag_out_d   = tag_in;
            out_valid_d = 1'b1;
            state_d     = DONE;
          end
        end else if ((state_q == DONE) && out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      SHIFT: begin
        if (cnt_q == SHAMT_ONE) begin
          result_d    = work_step;
          zero_d      = (work_step == '0);
          tag_out_d   = tag_pend_q;
          out_valid_d = 1'b1;
          cnt_d       = '0;
          state_d     = DONE;
        end else begin
          work_d = work_step;
          cnt_d  = cnt_q - SHAMT_ONE;
        end
      end
      default: begin
        out_valid_d = 1'b0;
        state_d     = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any shift in progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      zero_q      <= 1'b0;
      tag_out_q   <= '0;
      tag_pend_q  <= '0;
      work_q      <= '0;
      cnt_q       <= '0;
      shl_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      zero_q      <= zero_d;
      tag_out_q   <= tag_out_d;
      tag_pend_q  <= tag_pend_d;
      work_q      <= work_d;
      cnt_q       <= cnt_d;
      shl_q       <= shl_d;
    end
  end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Self-checking bench for alu_exec_unit: directed scenarios plus random
// operations compared against a plain-arithmetic reference model.
module tb_alu_exec_unit;

  localparam int WIDTH = 32;
  localparam int TAG_W = 5;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       ALUControl;
  logic [WIDTH-1:0] SrcA;
  logic [WIDTH-1:0] SrcB;
  logic [TAG_W-1:0] tag_in;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] ALUResult;
  logic             Zero;
  logic [TAG_W-1:0] tag_out;

  int n_checks = 0;
  int n_errors = 0;

  alu_exec_unit #(.WIDTH(WIDTH), .TAG_W(TAG_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .ALUControl (ALUControl),
    .SrcA       (SrcA),
    .SrcB       (SrcB),
    .tag_in     (tag_in),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .ALUResult  (ALUResult),
    .Zero       (Zero),
    .tag_out    (tag_out)
  );

  always #5 clk = ~clk;

  // Compare one observed value with its expected value.
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    int sh;
    sh = int'(b % 32);
    case (op)
      3'd0:    return a + b;
      3'd1:    return a - b;
      3'd2:    return a & b;
      3'd3:    return a | b;
      3'd4:    return a ^ b;
      3'd5:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3'd6:    return a << sh;
      default: return a >> sh;
    endcase
  endfunction

  function automatic int model_lat(input logic [2:0] op, input logic [31:0] b);
    int sh;
    sh = int'(b % 32);
    if (op >= 3'd6 && sh != 0) return sh;
    return 1;
  endfunction

  // Issue one operation (called just after a negedge), wait for its result,
  // check latency and values, then optionally stall the output for `stall` cycles.
  task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] t, input int stall);
    logic [31:0] er;
    int el;
    int lat;
    er = model(op, a, b);
    el = model_lat(op, b);
    ALUControl = op;
    SrcA       = a;
    SrcB       = b;
    tag_in     = t;
    in_valid   = 1'b1;
    out_ready  = 1'b1;
    #1;
    chk("in_ready_before_accept", in_ready, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    SrcA     = $urandom;
    SrcB     = $urandom;
    lat = 0;
    while (1) begin
      @(negedge clk);
      lat++;
      if (out_valid) break;
      chk("in_ready_during_shift", in_ready, 0);
      out_ready = 1'($urandom_range(0, 1));
      if (lat > 80) begin
        chk("result_timeout", lat, el);
        break;
      end
    end
    chk("latency", lat, el);
    chk("result", ALUResult, er);
    chk("zero", Zero, (er == 0));
    chk("tag", tag_out, t);
    out_ready = 1'b0;
    for (int k = 0; k < stall; k++) begin
      @(negedge clk);
      chk("stall_valid", out_valid, 1);
      chk("stall_result", ALUResult, er);
      chk("stall_tag", tag_out, t);
      chk("stall_in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] sr [3];
    logic [2:0]  sop [3];

    rst_n      = 1'b0;
    in_valid   = 1'b0;
    out_ready  = 1'b1;
    ALUControl = 3'd0;
    SrcA       = '0;
    SrcB       = '0;
    tag_in     = '0;
    repeat (3) @(negedge clk);
    chk("reset_out_valid", out_valid, 0);
    chk("reset_result", ALUResult, 0);
    chk("reset_zero", Zero, 0);
    chk("reset_tag", tag_out, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("reset_in_ready", in_ready, 1);

    // add, then idle cycle drops out_valid
    do_op(3'd0, 32'd5, 32'd7, 5'd1, 0);
    @(negedge clk);
    chk("add_valid_clears", out_valid, 0);

    // beq-style compare and signed slt
    do_op(3'd1, 32'h10, 32'h10, 5'd2, 0);
    do_op(3'd5, 32'hFFFF_FFFF, 32'd1, 5'd3, 0);

    // long shifts, including upper shift-amount bits ignored
    do_op(3'd6, 32'd1, 32'd31, 5'd4, 0);
    do_op(3'd7, 32'h8000_0000, 32'h24, 5'd5, 0);
    do_op(3'd6, 32'h0000_00F0, 32'h21, 5'd6, 0);

    // shift by zero passes SrcA through in one cycle
    do_op(3'd6, 32'hDEAD_BEEF, 32'd0, 5'd7, 0);

    // back-to-back stream: xor/or/and with tags 1,2,3
    sop[0] = 3'd4; sop[1] = 3'd3; sop[2] = 3'd2;
    @(negedge clk);
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      ALUControl = sop[i];
      SrcA       = 32'h0F0F_1234 + i;
      SrcB       = 32'h00FF_4321 << i;
      tag_in     = 5'(i + 1);
      sr[i]      = model(sop[i], SrcA, SrcB);
      in_valid   = 1'b1;
      @(negedge clk);
      chk("stream_valid", out_valid, 1);
      chk("stream_result", ALUResult, sr[i]);
      chk("stream_tag", tag_out, i + 1);
    end
    // hold downstream off; a pending new input must be ignored
    out_ready  = 1'b0;
    ALUControl = 3'd0;
    SrcA       = 32'd100;
    SrcB       = 32'd23;
    tag_in     = 5'd4;
    #1;
    chk("stall_in_ready", in_ready, 0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("hold_valid", out_valid, 1);
      chk("hold_result", ALUResult, sr[2]);
      chk("hold_tag", tag_out, 3);
      chk("hold_in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("after_stall_result", ALUResult, 32'd123);
    chk("after_stall_tag", tag_out, 4);
    in_valid = 1'b0;
    @(negedge clk);
    chk("after_stall_idle", out_valid, 0);

    // reset in the third cycle of an sll by 10
    ALUControl = 3'd6;
    SrcA       = 32'd3;
    SrcB       = 32'd10;
    tag_in     = 5'd9;
    in_valid   = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midshift_rst_valid", out_valid, 0);
    chk("midshift_rst_result", ALUResult, 0);
    chk("midshift_rst_tag", tag_out, 0);
    chk("midshift_rst_in_ready", in_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      chk("no_result_after_abort", out_valid, 0);
    end
    chk("in_ready_after_abort", in_ready, 1);
    do_op(3'd0, 32'hFFFF_FFFF, 32'd2, 5'd10, 0);

    // randomized operations with random output stalls
    for (int n = 0; n < 40; n++) begin
      op = 3'($urandom_range(0, 7));
      a  = $urandom;
      case ($urandom_range(0, 3))
        0:       b = a;
        1:       b = 32'($urandom_range(0, 40));
        default: b = $urandom;
      endcase
      do_op(op, a, b, 5'($urandom_range(0, 31)), $urandom_range(0, 2));
    end
    @(negedge clk);
    chk("final_idle", out_valid, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/alu_exec_unit.md
Name: alu_exec_unit

Overview:
Execute-stage ALU that consumes the 3-bit ALUControl code from the ALU decoder, along with two operands, and produces ALUResult and the Zero flag.
- Add, sub, and, or, xor and slt complete in one registered cycle.
- Shifts run iteratively, one bit per cycle, so no 32-bit barrel shifter is needed.
- A valid/ready handshake on both sides lets the control path stall fetch/decode while a shift is in progress.

Parameters:
WIDTH, 32, operand and result width (power of two, >= 8)
TAG_W, 5, width of destination-register tag carried alongside the operation
SHAMT_W, $clog2(WIDTH), shift amount width, taken from SrcB[SHAMT_W-1:0]

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operation presented on the input side
in_ready  output  1  unit can accept an operation this cycle
ALUControl  input  3  000 add, 001 sub, 010 and, 011 or, 100 xor, 101 slt, 110 sll, 111 srl
SrcA  input  WIDTH  operand A
SrcB  input  WIDTH  operand B; low SHAMT_W bits form the shift amount
tag_in  input  TAG_W  destination tag, passed through unchanged
out_valid  output  1  result available
out_ready  input  1  downstream accepts the result
ALUResult  output  WIDTH  registered result
Zero  output  1  registered (ALUResult == 0), used for beq/bne
tag_out  output  TAG_W  tag of the operation that produced the current result

Behaviour:
Clock, reset and outputs:
- One clock. rst_n is asynchronous, active-low, and may deassert synchronously.
- Reset values: state IDLE, out_valid=0, ALUResult=0, Zero=0, tag_out=0, shift counter=0.
- After reset, in_ready=1.
- All outputs except in_ready are registered.
- in_ready = (state==IDLE) | (state==DONE & out_ready). This is combinational from state and out_ready only, with no path from in_valid.

Handshake:
- Accept occurs when in_valid & in_ready at a rising edge. Operands, ALUControl and tag are captured at that edge.
- Output transfer occurs when out_valid & out_ready.
- While out_valid=1 and not yet accepted, ALUResult, Zero and tag_out hold stable.

State machine (IDLE, SHIFT, DONE):
- IDLE, accept, non-shift op: compute the result into the output registers and go to DONE. Result is valid at the edge after accept (latency 1).
- IDLE, accept, shift op with shamt==0: ALUResult=SrcA, go to DONE (latency 1).
- IDLE, accept, shift op with shamt>0: load the working register with SrcA and the counter with shamt, then go to SHIFT.
- SHIFT: each cycle, shift the working register by one bit (sll: left, zero fill; srl: right, zero fill) and decrement the counter.
  - When the counter reaches 1, the final shift result is written to ALUResult and the state goes to DONE.
  - Total latency from accept to out_valid is shamt cycles.
  - in_ready=0 throughout SHIFT.
- DONE with out_ready=1: if a new accept happens in the same cycle, process it exactly as from IDLE (back-to-back single-cycle ops sustain 1 op/cycle). Otherwise go to IDLE and clear out_valid.
- DONE with out_ready=0: hold.

Arithmetic:
- add and sub wrap modulo 2^WIDTH; no overflow or carry outputs.
- slt is a signed compare of SrcA and SrcB; the result is 1 or 0, zero-extended.
- Undefined codes cannot occur; all 8 codes are defined.
- The srl code (111) is also issued by the decoder for sra; this unit performs a logical shift. An arithmetic variant needs an extra control bit and is out of scope.
- Zero is computed from the final result in the same edge that ALUResult is written.

Boundary conditions:
- shamt uses only SrcB[SHAMT_W-1:0]; upper bits are ignored (SrcB=0x21 shifts by 1 at WIDTH=32).
- Reset asserted mid-SHIFT: the operation is aborted immediately, no result is produced, and the reset values apply.
- in_valid while in_ready=0 is ignored; the source must hold its inputs.
- out_ready toggling while in SHIFT has no effect.

Test Plan:
1. Reset, then accept add SrcA=5, SrcB=7 at cycle t with out_ready=1: ALUResult=12, Zero=0, out_valid=1 at t+1; out_valid=0 at t+2 if no new input.
2. Accept sub SrcA=0x10, SrcB=0x10 (beq-style compare): ALUResult=0, Zero=1. Then slt SrcA=0xFFFFFFFF, SrcB=1: ALUResult=1.
3. Accept sll SrcA=1, SrcB=31: in_ready=0 for the SHIFT cycles, out_valid rises exactly 31 cycles after accept, ALUResult=0x80000000. Then srl SrcA=0x80000000, SrcB=0x24: ALUResult=0x08000000 after 4 cycles.
4. Shift with SrcB=0, SrcA=0xDEADBEEF: latency 1, ALUResult=0xDEADBEEF.
5. Back-to-back xor/or/and stream with out_ready=1: one result per cycle, tags 1,2,3 emerge in order. Then hold out_ready=0 for 3 cycles: outputs stable, in_ready=0.
6. Assert rst_n=0 at the third cycle of an sll by 10: out_valid stays 0, ALUResult=0. After release, in_ready=1 and a fresh add completes correctly.
